ssc_tx_chan: RTL and testbench

- Spread-spectrum transmit channel: the transmit-side counterpart of the ssc correlator channels.
- On each sample strobe it synthesises a BPSK-spread carrier sample: carrier DDS → quarter-wave sine, multiplied by ±1 from the chip-rate PRN LFSR, then scaled.
- Output is a 16-bit signed word with a push strobe, shaped like the ADC/pushADC pair the receive channels consume, so it can drive them directly in loopback benches.
- Programmed over the same addr/Wdata/write/read/Rdata register bus.

---
 rtl/ssc_pkg.sv | 38 +++
 rtl/ssc_prn_step.sv | 22 ++
 rtl/ssc_sin_rom.sv | 28 ++
 rtl/ssc_tx_chan.sv | 195 +++++++++++++++++++
 tb/tb_ssc_tx_chan.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/ssc_pkg.sv
// Shared definitions for the ssc channels: register offsets, PRN field layout,
// output saturation limits and the register-select type used by the bus decode.
package ssc_pkg;

    localparam logic [15:0] OFF_CTRL = 16'h00;
    localparam logic [15:0] OFF_CADD = 16'h04;
    localparam logic [15:0] OFF_CPH  = 16'h08;
    localparam logic [15:0] OFF_CHF  = 16'h0C;
    localparam logic [15:0] OFF_CHPH = 16'h10;
    localparam logic [15:0] OFF_PRN  = 16'h14;
    localparam logic [15:0] OFF_AMP  = 16'h18;
    localparam logic [15:0] OFF_SCNT = 16'h1C;
    localparam logic [15:0] OFF_ECNT = 16'h20;
    localparam logic [15:0] OFF_STAT = 16'h24;

    localparam int HOB_MSB   = 31;
    localparam int POLY_MSB  = 27;
    localparam int STATE_MSB = 13;
    localparam int HOB_W     = 4;
    localparam int POLY_W    = 14;
    localparam int STATE_W   = 14;

    localparam logic signed [15:0] SAT_HI = 16'sh7FFF;
    localparam logic signed [15:0] SAT_LO = 16'sh8001;

    typedef enum logic [3:0] {
        SEL_CTRL, SEL_CADD, SEL_CPH, SEL_CHF, SEL_CHPH,
        SEL_PRN, SEL_AMP, SEL_SCNT, SEL_ECNT, SEL_STAT, SEL_NONE
    } reg_sel_e;

    // Symmetric clamp so a negated full-scale sample never wraps.
    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'(SAT_HI)) return SAT_HI;
        if (v < 19'(SAT_LO)) return SAT_LO;
        return 16'(v);
    endfunction

endpackage

// File: rtl/ssc_prn_step.sv
// Combinational PRN LFSR next-state: output bit is state[hob] (0 when hob is
// out of range); that bit is cleared, the state shifts left, and poly is folded in.
module ssc_prn_step
    import ssc_pkg::*;
(
    input  logic [HOB_W-1:0]   hob_i,
    input  logic [POLY_W-1:0]  poly_i,
    input  logic [STATE_W-1:0] state_i,
    output logic [STATE_W-1:0] state_o,
    output logic               bit_o
);

    logic [STATE_W-1:0] mask;

    always_comb begin
        // hob of 14/15 shifts the mask out entirely, giving a zero bit and no clear.
        mask    = STATE_W'(1) << hob_i;
        bit_o   = |(state_i & mask);
        state_o = ((state_i & ~mask) << 1) ^ (bit_o ? poly_i : '0);
    end

endmodule

// File: rtl/ssc_sin_rom.sv
// Quarter-wave sine ROM, one-cycle registered read. Content is the parabolic
// quarter-wave a*(2N-a) scaled so the last entry is 32767 and entry 0 is 0.
module ssc_sin_rom #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic [15:0]   data_o
);

    localparam int SH = 2 * AW - 15;

    logic [AW+1:0]   ax, cx;
    logic [2*AW+3:0] prod;

    always_comb begin
        ax   = {2'b00, addr_i};
        cx   = {1'b1, {(AW + 1){1'b0}}} - ax;
        prod = (2*AW+4)'(ax) * (2*AW+4)'(cx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_o <= '0;
        else     data_o <= 16'(prod >> SH);
    end

endmodule

// File: rtl/ssc_tx_chan.sv
// Spread-spectrum transmit channel: carrier DDS -> quarter-wave sine, BPSK by PRN chip,
// scaled to a 16-bit DAC word. Define SSC_TX_DITHER_EN for the gated 2-bit LFSR dither.
module ssc_tx_chan
    import ssc_pkg::*;
#(
    parameter logic [15:0] BASE   = 16'h0800,
    parameter int          SIN_AW = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] Wdata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] Rdata,
    input  logic        tick,
    output logic [15:0] DAC,
    output logic        pushDAC,
    output logic        epoch
);

    localparam int STAGES = 3;

    reg_sel_e    sel;
    logic [15:0] off;
    logic        unused_addr;

    logic        run_q;
    logic [31:0] cadd_q, cph_q, chf_q, chph_q, prn_q, scnt_q, ecnt_q;
    logic [15:0] amp_q;
    logic        stat_q, rd_stat_q, epoch_q;

    logic               adv, prn_edge, epoch_set, ctrl_b1;
    logic [31:0]        cph_sum, chph_sum;
    logic [STATE_W-1:0] prn_nxt;
    logic               prn_bit;

    logic [STAGES-1:0]        vld_pipe;
    logic [SIN_AW-1:0]        rom_addr;
    logic [15:0]              sv;
    logic                     neg1_q;
    logic signed [15:0]       s2_q;
    logic signed [32:0]       prod;
    logic signed [18:0]       dith, s3_sum;
    logic [15:0]              dac_q;

    assign unused_addr = ^addr[31:16];

    always_comb begin
        off = addr[15:0] - BASE;
        case (off)
            OFF_CTRL: sel = SEL_CTRL;
            OFF_CADD: sel = SEL_CADD;
            OFF_CPH:  sel = SEL_CPH;
            OFF_CHF:  sel = SEL_CHF;
            OFF_CHPH: sel = SEL_CHPH;
            OFF_PRN:  sel = SEL_PRN;
            OFF_AMP:  sel = SEL_AMP;
            OFF_SCNT: sel = SEL_SCNT;
            OFF_ECNT: sel = SEL_ECNT;
            OFF_STAT: sel = SEL_STAT;
            default:  sel = SEL_NONE;
        endcase
    end

    assign adv      = tick && run_q;
    assign cph_sum  = cph_q + cadd_q;
    assign chph_sum = chph_q + chf_q;
    assign prn_edge = adv && chph_sum[31] && !chph_q[31];
    // A PRN write in the step cycle replaces the step, so it cannot raise an epoch.
    assign epoch_set = prn_edge && !(write && sel == SEL_PRN) && (prn_nxt == 14'h0001);

    ssc_prn_step u_prn (
        .hob_i   (prn_q[HOB_MSB -: HOB_W]),
        .poly_i  (prn_q[POLY_MSB -: POLY_W]),
        .state_i (prn_q[STATE_MSB:0]),
        .state_o (prn_nxt),
        .bit_o   (prn_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            cadd_q    <= '0;
            cph_q     <= '0;
            chf_q     <= '0;
            chph_q    <= '0;
            prn_q     <= '0;
            amp_q     <= '0;
            scnt_q    <= '0;
            ecnt_q    <= '0;
            stat_q    <= 1'b0;
            rd_stat_q <= 1'b0;
            epoch_q   <= 1'b0;
        end else begin
            if (write && sel == SEL_CTRL) run_q  <= Wdata[0];
            if (write && sel == SEL_CADD) cadd_q <= Wdata;
            if (write && sel == SEL_CHF)  chf_q  <= Wdata;
            if (write && sel == SEL_AMP)  amp_q  <= Wdata[15:0];

            if (write && sel == SEL_CPH)       cph_q <= Wdata;
            else if (adv)                      cph_q <= cph_sum;
            if (write && sel == SEL_CHPH)      chph_q <= Wdata;
            else if (adv)                      chph_q <= chph_sum;
            if (write && sel == SEL_PRN)       prn_q <= Wdata;
            else if (prn_edge)                 prn_q[STATE_MSB:0] <= prn_nxt;
            if (write && sel == SEL_SCNT)      scnt_q <= Wdata;
            else if (adv)                      scnt_q <= scnt_q + 32'd1;
            if (write && sel == SEL_ECNT)      ecnt_q <= Wdata;
            else if (epoch_set)                ecnt_q <= ecnt_q + 32'd1;

            epoch_q   <= epoch_set;
            rd_stat_q <= read && sel == SEL_STAT;
            if (epoch_set)                                   stat_q <= 1'b1;
            else if (read && sel == SEL_STAT && !rd_stat_q)  stat_q <= 1'b0;
        end
    end

    // Quadrants 1/3 walk the quarter wave backwards; 2/3 flip the sign.
    assign rom_addr = cph_q[30] ? ~cph_q[29 -: SIN_AW] : cph_q[29 -: SIN_AW];

    ssc_sin_rom #(.AW(SIN_AW)) u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (rom_addr),
        .data_o (sv)
    );

`ifdef SSC_TX_DITHER_EN
    logic        dith_en_q;
    logic [15:0] lfsr_q;
    logic [1:0]  d1_q, d2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dith_en_q <= 1'b0;
            lfsr_q    <= 16'hACE1;
            d1_q      <= '0;
            d2_q      <= '0;
        end else begin
            if (write && sel == SEL_CTRL) dith_en_q <= Wdata[1];
            if (tick) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (adv) d1_q <= dith_en_q ? lfsr_q[1:0] : 2'b00;
            if (vld_pipe[0]) d2_q <= d1_q;
        end
    end

    assign ctrl_b1 = dith_en_q;
    assign dith    = 19'($signed(d2_q));
`else
    assign ctrl_b1 = 1'b0;
    assign dith    = '0;
`endif

    assign prod   = 33'(s2_q) * 33'($signed({1'b0, amp_q}));
    assign s3_sum = 19'(prod >>> 15) + dith;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            neg1_q   <= 1'b0;
            s2_q     <= '0;
            dac_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], adv};
            if (adv)         neg1_q <= cph_q[31] ^ prn_bit;
            if (vld_pipe[0]) s2_q   <= neg1_q ? -$signed(sv) : $signed(sv);
            if (vld_pipe[1]) dac_q  <= sat16(s3_sum);
        end
    end

    assign DAC     = dac_q;
    assign pushDAC = vld_pipe[STAGES-1];
    assign epoch   = epoch_q;

    always_comb begin
        Rdata = '0;
        if (read) begin
            case (sel)
                SEL_CTRL: Rdata = {30'b0, ctrl_b1, run_q};
                SEL_CADD: Rdata = cadd_q;
                SEL_CPH:  Rdata = cph_q;
                SEL_CHF:  Rdata = chf_q;
                SEL_CHPH: Rdata = chph_q;
                SEL_PRN:  Rdata = prn_q;
                SEL_AMP:  Rdata = {16'b0, amp_q};
                SEL_SCNT: Rdata = scnt_q;
                SEL_ECNT: Rdata = ecnt_q;
                SEL_STAT: Rdata = {31'b0, stat_q};
                default:  Rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ssc_tx_chan.sv
// Directed bench for ssc_tx_chan: quadrants, spreading, saturation, PRN sequence/epoch,
// mid-run control and reset-in-flight, with hand-computed expectations.
module tb_ssc_tx_chan;

    logic        clk = 1'b0;
    logic        rst, write, read, tick, pushDAC, epoch;
    logic [31:0] addr, Wdata, Rdata;
    logic [15:0] DAC;
    int          total = 0, bad = 0, push_cnt = 0, ep_cnt = 0;

    localparam logic [7:0] CTRL = 8'h00, CADD = 8'h04, CPH = 8'h08, CHF = 8'h0C,
                           CHPH = 8'h10, PRN = 8'h14, AMP = 8'h18, SCNT = 8'h1C,
                           ECNT = 8'h20, STAT = 8'h24;

    ssc_tx_chan dut (
        .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
        .Rdata(Rdata), .tick(tick), .DAC(DAC), .pushDAC(pushDAC), .epoch(epoch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pushDAC) push_cnt++;
        if (epoch)   ep_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        addr = 32'h0000_0800 + 32'(off); Wdata = d; write = 1'b1;
        @(negedge clk); write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        addr = 32'h0000_0800 + 32'(off); read = 1'b1;
        #1 d = Rdata;
        @(negedge clk); read = 1'b0;
    endtask

    task automatic tick1();
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    // Called right after tick1: push must be absent one cycle later and present two later.
    task automatic wait_push(input string tag, input logic [15:0] exp);
        @(negedge clk); chk({tag, "_early"}, 32'(pushDAC), 32'd0);
        @(negedge clk); chk({tag, "_push"}, 32'(pushDAC), 32'd1);
        chk(tag, 32'(DAC), 32'(exp));
    endtask

    initial begin
        logic [31:0] r, sc0;
        logic [13:0] seq [15];
        int pc0, ep0;
        seq = '{14'd2, 14'd4, 14'd8, 14'd3, 14'd6, 14'd12, 14'd11, 14'd5,
                14'd10, 14'd7, 14'd14, 14'd15, 14'd13, 14'd9, 14'd1};
        rst = 1'b1; write = 1'b0; read = 1'b0; tick = 1'b0; addr = '0; Wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_dac", 32'(DAC), 32'd0);
        chk("rst_push", 32'(pushDAC), 32'd0);
        chk("rst_epoch", 32'(epoch), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rd(8'(i * 4), r); chk($sformatf("rst_reg%0h", i * 4), r, 32'd0);
        end
        rd(8'h28, r); chk("unmapped", r, 32'd0);

        // Quadrant sweep: 0, +peak, 0, -peak at unity gain.
        wr(AMP, 32'h8000); wr(CADD, 32'h4000_0000); wr(CTRL, 32'd1);
        tick1(); wait_push("quad0", 16'h0000);
        tick1(); wait_push("quad1", 16'h7FFF);
        tick1(); wait_push("quad2", 16'h0000);
        tick1(); wait_push("quad3", 16'h8001);
        rd(SCNT, r); chk("scnt4", r, 32'd4);
        rd(CPH, r);  chk("cph_wrap", r, 32'd0);
        rd(CTRL, r); chk("ctrl_rd", r, 32'd1);

        // Spreading: chip bit 1 inverts the quadrant-1 peak.
        wr(CADD, 32'd0); wr(CPH, 32'h4000_0000); wr(PRN, 32'h0000_0001);
        tick1(); wait_push("spread", 16'h8001);

        // Saturation at near-double gain.
        wr(PRN, 32'd0); wr(AMP, 32'hFFFF);
        tick1(); wait_push("sat_pos", 16'h7FFF);
        wr(CPH, 32'hC000_0000);
        tick1(); wait_push("sat_neg", 16'h8001);

        // PRN sequence: one step every two ticks, period 15.
        wr(CHPH, 32'd0); wr(CHF, 32'h8000_0000); wr(PRN, 32'h3000_C001);
        ep0 = ep_cnt;
        for (int k = 0; k < 15; k++) begin
            tick1(); tick1();
            rd(PRN, r); chk($sformatf("prn_step%0d", k), r, 32'h3000_C000 | 32'(seq[k]));
        end
        repeat (4) @(negedge clk);
        chk("epoch_pulses", 32'(ep_cnt - ep0), 32'd1);
        rd(ECNT, r); chk("ecnt", r, 32'd1);
        rd(STAT, r); chk("stat_set", r, 32'd1);
        rd(STAT, r); chk("stat_clr", r, 32'd0);
        wr(STAT, 32'hFFFF_FFFF);
        rd(STAT, r); chk("stat_ro", r, 32'd0);

        // Write coincident with advance: write wins, counters still advance.
        wr(CHF, 32'd0); wr(CADD, 32'h1000_0000);
        rd(SCNT, sc0);
        addr = 32'h0000_0800 + 32'(CPH); Wdata = 32'h8000_0000; write = 1'b1; tick = 1'b1;
        @(negedge clk); write = 1'b0; tick = 1'b0;
        rd(CPH, r);  chk("wr_vs_adv", r, 32'h8000_0000);
        rd(SCNT, r); chk("scnt_adv", r, sc0 + 32'd1);
        repeat (4) @(negedge clk);

        // Clear run under continuous ticks: three advances drain, nothing more.
        #1 pc0 = push_cnt;
        rd(SCNT, sc0);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        addr = 32'h0000_0800 + 32'(CTRL); Wdata = 32'd0; write = 1'b1;
        @(negedge clk); write = 1'b0;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("drain_pushes", 32'(push_cnt - pc0), 32'd3);
        rd(SCNT, r); chk("drain_scnt", r, sc0 + 32'd3);

        // Reset between a tick and its push.
        wr(CTRL, 32'd1);
        #1 pc0 = push_cnt;
        tick1();
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk("rst_nopush", 32'(push_cnt - pc0), 32'd0);
        chk("rst2_dac", 32'(DAC), 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd(8'(i * 4), r); chk($sformatf("rst2_reg%0h", i * 4), r, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
